// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
package disp_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_t;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low segment pattern decoder.
module hex_to_7seg
   import disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[nibble];

endmodule

// File: rtl/display_mux_7seg.sv
// 4-digit common-anode 7-segment scanner with valid/ready input and
// frame-aligned commit of buffered values.
//
// state    | meaning
// ST_BLANK | dead time, all anodes off
// ST_DRIVE | digit idx driven (unless leading-zero blanked)
module display_mux_7seg
   import disp_pkg::*;
#(
   parameter int unsigned DRIVE_CYCLES = 99000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [15:0] value_i,
   input  logic [3:0]  dp_i,
   input  logic        blank_lz_i,
   output logic        ready_o,
   output logic [3:0]  an_o,
   output logic [6:0]  seg_o,
   output logic        dp_o
);

   localparam int unsigned MAX_CYCLES =
      (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
   localparam int CNT_W = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_CYCLES);
   localparam logic [CNT_W-1:0] DRIVE_TC = CNT_W'(DRIVE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q, state_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic [1:0]       idx_q, idx_n;
   logic             commit;
   logic             transfer;

   logic [15:0] pend_value_q;
   logic [3:0]  pend_dp_q;
   logic        pend_lz_q;
   logic        pend_full_q, pend_full_n;

   logic [15:0] disp_value_q;
   logic [3:0]  disp_dp_q;
   logic        disp_lz_q;

   logic [3:0]  nibble;
   logic [6:0]  seg_dec;
   logic        lz_blank;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n;

   // Entry into a state loads 1 so each state lasts exactly its terminal
   // count; the reset value 0 makes the first BLANK after reset equally long
   // when counted from the release edge.
   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q + CNT_ONE;
      idx_n   = idx_q;
      commit  = 1'b0;
      if (state_q == ST_BLANK) begin
         if (cnt_q == BLANK_TC) begin
            state_n = ST_DRIVE;
            cnt_n   = CNT_ONE;
         end
      end else begin
         if (cnt_q == DRIVE_TC) begin
            state_n = ST_BLANK;
            cnt_n   = CNT_ONE;
            idx_n   = idx_q + 2'd1;
            commit  = (idx_q == 2'd3) && pend_full_q;
         end
      end
   end

   assign transfer    = valid_i && ready_o;
   assign pend_full_n = transfer || (pend_full_q && !commit);

   assign nibble = disp_value_q[{idx_q, 2'b00} +: 4];

   hex_to_7seg u_dec (
      .nibble (nibble),
      .seg_o  (seg_dec)
   );

   always_comb begin
      lz_blank = 1'b0;
      if (disp_lz_q) begin
         case (idx_q)
            2'd1:    lz_blank = (disp_value_q[15:4] == 12'h000);
            2'd2:    lz_blank = (disp_value_q[15:8] == 8'h00);
            2'd3:    lz_blank = (disp_value_q[15:12] == 4'h0);
            default: lz_blank = 1'b0;
         endcase
      end
   end

   // idx and display only change on DRIVE->BLANK, so a DRIVE next state
   // always uses the current idx and display contents.
   always_comb begin
      an_n  = AN_OFF;
      seg_n = SEG_OFF;
      dp_n  = 1'b1;
      if (state_n == ST_DRIVE && !lz_blank) begin
         an_n  = ~(4'b0001 << idx_q);
         seg_n = seg_dec;
         dp_n  = ~disp_dp_q[idx_q];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_BLANK;
         cnt_q        <= '0;
         idx_q        <= 2'd0;
         pend_value_q <= 16'h0000;
         pend_dp_q    <= 4'h0;
         pend_lz_q    <= 1'b0;
         pend_full_q  <= 1'b0;
         disp_value_q <= 16'h0000;
         disp_dp_q    <= 4'h0;
         disp_lz_q    <= 1'b0;
         ready_o      <= 1'b0;
         an_o         <= AN_OFF;
         seg_o        <= SEG_OFF;
         dp_o         <= 1'b1;
      end else begin
         state_q     <= state_n;
         cnt_q       <= cnt_n;
         idx_q       <= idx_n;
         pend_full_q <= pend_full_n;
         if (transfer) begin
            pend_value_q <= value_i;
            pend_dp_q    <= dp_i;
            pend_lz_q    <= blank_lz_i;
         end
         if (commit) begin
            disp_value_q <= pend_value_q;
            disp_dp_q    <= pend_dp_q;
            disp_lz_q    <= pend_lz_q;
         end
         ready_o <= !pend_full_n;
         an_o    <= an_n;
         seg_o   <= seg_n;
         dp_o    <= dp_n;
      end
   end

endmodule
